// File: rtl/proc_defs_pkg.sv
// Shared pipeline definitions: word/address widths, fetch FSM encodings and
// the IF/ID entry layout used by fetch and decode.
package proc_defs;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 20;
  localparam int IMM_FLAG_BIT = 0;

  localparam logic [ADDR_W-1:0] RESET_VEC_HI_ADDR = '0;
  localparam logic [ADDR_W-1:0] RESET_VEC_LO_ADDR = ADDR_W'(1);

  typedef enum logic [1:0] {
    VEC_HI    = 2'd0,
    VEC_LO    = 2'd1,
    FETCH     = 2'd2,
    FETCH_IMM = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] imm;
    logic              has_imm;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load replaces the whole entry, clear only kills
// valid so the payload stays readable for debug.
module if_id_reg
  import proc_defs::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_ld,
  input  logic   i_clr,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q       <= '0;
    else if (i_clr) r_q.valid <= 1'b0;
    else if (i_ld)  r_q       <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: loads the reset vector from words 0/1, then fetches
// sequentially, folding two-word instructions into a single IF/ID entry.
module fetch_stage
  import proc_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_imm,
  output logic              if_has_imm,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_next_pc
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_hold_pc;
  logic [DATA_W-1:0] r_hold_instr;

  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_imm_flag;
  logic              w_ld;
  logic              w_clr;
  if_id_t            w_d;
  if_id_t            w_q;

  // Wraps modulo 2^ADDR_W, so an immediate after 0xFFFFF comes from 0.
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_imm_flag = imem_data[IMM_FLAG_BIT];

  always_comb begin
    case (r_state)
      VEC_HI:  imem_addr = RESET_VEC_HI_ADDR;
      VEC_LO:  imem_addr = RESET_VEC_LO_ADDR;
      default: imem_addr = r_pc;
    endcase
  end

  always_comb begin
    w_ld  = 1'b0;
    w_clr = 1'b0;
    w_d   = '0;
    case (r_state)
      FETCH: begin
        if (redirect_valid) begin
          w_clr = 1'b1;
        end else if (!stall) begin
          if (w_imm_flag) begin
            w_clr = 1'b1;
          end else begin
            w_ld      = 1'b1;
            w_d.valid = 1'b1;
            w_d.instr = imem_data;
            w_d.pc    = r_pc;
            w_d.next_pc = w_pc_inc;
          end
        end
      end
      FETCH_IMM: begin
        if (redirect_valid) begin
          w_clr = 1'b1;
        end else if (!stall) begin
          w_ld        = 1'b1;
          w_d.valid   = 1'b1;
          w_d.instr   = r_hold_instr;
          w_d.imm     = imem_data;
          w_d.has_imm = 1'b1;
          w_d.pc      = r_hold_pc;
          w_d.next_pc = w_pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= VEC_HI;
      r_pc         <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      case (r_state)
        VEC_HI: begin
          r_pc[ADDR_W-1:16] <= imem_data[ADDR_W-17:0];
          r_state           <= VEC_LO;
        end
        VEC_LO: begin
          r_pc[15:0] <= imem_data;
          r_state    <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else if (!stall) begin
            r_pc <= w_pc_inc;
            if (w_imm_flag) begin
              r_hold_instr <= imem_data;
              r_hold_pc    <= r_pc;
              r_state      <= FETCH_IMM;
            end
          end
        end
        FETCH_IMM: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= FETCH;
          end else if (!stall) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end
        end
        default: r_state <= VEC_HI;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .i_ld  (w_ld),
    .i_clr (w_clr),
    .i_d   (w_d),
    .o_q   (w_q)
  );

  assign if_valid   = w_q.valid;
  assign if_instr   = w_q.instr;
  assign if_imm     = w_q.imm;
  assign if_has_imm = w_q.has_imm;
  assign if_pc      = w_q.pc;
  assign if_next_pc = w_q.next_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small instruction memory model, expected
// IF/ID entries queued as stimulus is set up and popped when they appear.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [19:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [19:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_imm;
  logic        if_has_imm;
  logic [19:0] if_pc;
  logic [19:0] if_next_pc;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has_imm;
    logic [19:0] pc;
    logic [19:0] next_pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem_lo [512];
  logic [15:0] mem_top;

  assign imem_data = (imem_addr < 20'd512)    ? mem_lo[imem_addr[8:0]] :
                     (imem_addr == 20'hFFFFF) ? mem_top : 16'h0000;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_imm         (if_imm),
    .if_has_imm     (if_has_imm),
    .if_pc          (if_pc),
    .if_next_pc     (if_next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_init();
    for (int i = 0; i < 512; i++) mem_lo[i] = 16'h0000;
    mem_top = 16'h0000;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] imm, input logic has_imm,
                      input logic [19:0] pc, input logic [19:0] next_pc);
    exp_t e;
    e.instr = instr; e.imm = imm; e.has_imm = has_imm; e.pc = pc; e.next_pc = next_pc;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"},   32'(if_valid),   32'd1);
      chk({tag, ".instr"},   32'(if_instr),   32'(e.instr));
      chk({tag, ".imm"},     32'(if_imm),     32'(e.imm));
      chk({tag, ".has_imm"}, 32'(if_has_imm), 32'(e.has_imm));
      chk({tag, ".pc"},      32'(if_pc),      32'(e.pc));
      chk({tag, ".next_pc"}, 32'(if_next_pc), 32'(e.next_pc));
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".valid"},   32'(if_valid),   32'd0);
    chk({tag, ".instr"},   32'(if_instr),   32'd0);
    chk({tag, ".imm"},     32'(if_imm),     32'd0);
    chk({tag, ".has_imm"}, 32'(if_has_imm), 32'd0);
    chk({tag, ".pc"},      32'(if_pc),      32'd0);
    chk({tag, ".next_pc"}, 32'(if_next_pc), 32'd0);
    chk({tag, ".addr"},    32'(imem_addr),  32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset vector 0x00020, one-word fetch, then a 3-cycle stall
    mem_init();
    mem_lo[1] = 16'h0020; mem_lo[9'h20] = 16'h1000; mem_lo[9'h21] = 16'h1002;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    chk("vec_hi_addr", 32'(imem_addr), 32'h0);
    step(); chk("vec_lo_addr", 32'(imem_addr), 32'h1);
    step(); chk("first_addr", 32'(imem_addr), 32'h20);
    chk("vec_no_valid", 32'(if_valid), 32'd0);
    push(16'h1000, 16'h0, 1'b0, 20'h00020, 20'h00021);
    step(); pop_check("vec_entry");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr",  32'(imem_addr),  32'h21);
      chk("stall.valid", 32'(if_valid),   32'd1);
      chk("stall.instr", 32'(if_instr),   32'h1000);
      chk("stall.pc",    32'(if_pc),      32'h20);
      chk("stall.npc",   32'(if_next_pc), 32'h21);
    end
    stall = 1'b0;
    push(16'h1002, 16'h0, 1'b0, 20'h00021, 20'h00022);
    step(); pop_check("after_stall");

    // Two-word instruction, then async reset while FETCH_IMM holds
    rst = 1'b1;
    mem_init();
    mem_lo[1] = 16'h0020; mem_lo[9'h20] = 16'h2001; mem_lo[9'h21] = 16'hBEEF;
    mem_lo[9'h22] = 16'h3000; mem_lo[9'h23] = 16'h6001; mem_lo[9'h24] = 16'h7777;
    @(negedge clk); rst = 1'b0;
    step(); step();
    push(16'h2001, 16'hBEEF, 1'b1, 20'h00020, 20'h00022);
    push(16'h3000, 16'h0000, 1'b0, 20'h00022, 20'h00023);
    step();
    chk("two_word_bubble", 32'(if_valid), 32'd0);
    chk("imm_addr", 32'(imem_addr), 32'h21);
    step(); pop_check("two_word");
    step(); pop_check("after_two_word");
    step(); chk("imm2_bubble", 32'(if_valid), 32'd0);
    #2 rst = 1'b1;
    #1 chk_cleared("async_reset");
    @(negedge clk); rst = 1'b0;
    chk("reload_hi", 32'(imem_addr), 32'h0);
    step(); chk("reload_lo", 32'(imem_addr), 32'h1);
    step(); chk("reload_fetch", 32'(imem_addr), 32'h20);

    // Redirect and stall together while in FETCH_IMM: redirect wins
    rst = 1'b1;
    mem_init();
    mem_lo[1] = 16'h0020; mem_lo[9'h20] = 16'h2001; mem_lo[9'h21] = 16'hBEEF;
    mem_lo[9'h100] = 16'h5000;
    @(negedge clk); rst = 1'b0;
    step(); step(); step();
    chk("pre_redirect_addr", 32'(imem_addr), 32'h21);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 20'h00100;
    step();
    chk("redirect_bubble", 32'(if_valid), 32'd0);
    chk("redirect_addr", 32'(imem_addr), 32'h100);
    stall = 1'b0; redirect_valid = 1'b0;
    push(16'h5000, 16'h0, 1'b0, 20'h00100, 20'h00101);
    step(); pop_check("redirect_target");

    // Wrap: vector 0xFFFFF; word 0 doubles as the vector-high word, so its
    // low nibble must be F and the same word becomes the immediate.
    rst = 1'b1;
    mem_init();
    mem_lo[0] = 16'h123F; mem_lo[1] = 16'hFFFF; mem_top = 16'h4001;
    @(negedge clk); rst = 1'b0;
    step(); step();
    chk("wrap_fetch_addr", 32'(imem_addr), 32'hFFFFF);
    step();
    chk("wrap_bubble", 32'(if_valid), 32'd0);
    chk("wrap_imm_addr", 32'(imem_addr), 32'h0);
    push(16'h4001, 16'h123F, 1'b1, 20'hFFFFF, 20'h00001);
    step(); pop_check("wrap_entry");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
